queue_ram_ctrl: RTL

Sequencing controller for the 1 kB queue: owns write/read pointers and occupancy for a 1024 x 8 single-port synchronous RAM, and drives the select of the 10-bit 2:1 address mux (write pointer vs. read pointer) in front of the RAM address port. It arbitrates push and pop requests onto the single RAM port, at most one access per cycle, with round-robin priority under contention. It sits between the queue's producer/consumer handshakes and the RAM plus address mux.

---
 rtl/queue_ram_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/queue_ram_ctrl.sv
// Sequencing controller for a 1024 x 8 single-port RAM queue: pointers, occupancy,
// round-robin push/pop arbitration onto the single port, and the address-mux select.
module queue_ram_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic              flush,
  output logic              push_ack,
  output logic              pop_ack,
  output logic              ram_we,
  output logic              ram_re,
  output logic              addr_sel,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic              pop_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  typedef enum logic {
    PRIO_PUSH = 1'b0,
    PRIO_POP  = 1'b1
  } prio_e;

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_INC = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_INC = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              pop_valid_q, pop_valid_d;
  prio_e             prio_q, prio_d;

  logic push_ok, pop_ok;

  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);

  // Acks are also gated by rst_n so nothing is granted while reset is held.
  assign push_ok = rst_n & push_req & ~full  & ~flush;
  assign pop_ok  = rst_n & pop_req  & ~empty & ~flush;

  assign push_ack = push_ok & (~pop_ok  | (prio_q == PRIO_PUSH));
  assign pop_ack  = pop_ok  & (~push_ok | (prio_q == PRIO_POP));

  assign ram_we   = push_ack;
  assign ram_re   = pop_ack;
  assign addr_sel = pop_ack;

  assign wr_ptr    = wr_ptr_q;
  assign rd_ptr    = rd_ptr_q;
  assign count     = count_q;
  assign pop_valid = pop_valid_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_valid_d = pop_ack;
    prio_d      = prio_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      pop_valid_d = 1'b0;
      prio_d      = PRIO_PUSH;
    end else begin
      if (push_ack) begin
        wr_ptr_d = wr_ptr_q + PTR_INC;
        count_d  = count_q + CNT_INC;
      end
      if (pop_ack) begin
        rd_ptr_d = rd_ptr_q + PTR_INC;
        count_d  = count_q - CNT_INC;
      end
      // Hand the next contention cycle to whichever side lost this one.
      if (push_ok && pop_ok) begin
        prio_d = push_ack ? PRIO_POP : PRIO_PUSH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      prio_q      <= PRIO_PUSH;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      prio_q      <= prio_d;
    end
  end

endmodule
